// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose:
//   Bundles the hazard-detection inputs, the debug-control requests and the
//   pipeline-register control outputs of pipeline_hazard_ctrl into one
//   interface. Only clk and rst_n stay outside as plain module ports.
//
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rt : instruction currently held in IF/ID
//   ex_mem_read, ex_rt                 : load in EX and its destination reg
//   mem_pc_src                         : branch resolved taken in MEM
//   halt_req (level), step_req (pulse) : debug requests
//   pc_we, if_id_we, if_id_flush,
//   id_ex_bubble, ex_mem_flush, pipe_en: pipeline register controls
//   halted                             : controller sits in HALTED
//   stall_count, flush_count           : saturating event counters
//
// Modports:
//   master : the side that drives the pipeline status (core / bench)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Pipeline status and debug requests
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_pc_src;
    logic             halt_req;
    logic             step_req;

    // Controller outputs
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_flush;
    logic             pipe_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_rt, mem_pc_src,
        output halt_req, step_req,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble,
        input  ex_mem_flush, pipe_en, halted,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_rt, mem_pc_src,
        input  halt_req, step_req,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble,
        output ex_mem_flush, pipe_en, halted,
        output stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central sequencing controller for a 5-stage pipeline
//   (fetch, decode, execute, memory, writeback).
//     - Load-use hazard: one-cycle stall (PC and IF/ID hold, bubble into ID/EX).
//     - Taken branch resolved in MEM: flush IF/ID, ID/EX and the WB/M fields
//       entering EX/MEM; highest priority, masks a coincident load-use.
//     - Debug FSM RUN / DRAIN / HALTED / STEP: on halt_req the front end is
//       drained with DRAIN_CYCLES nop slots, then the whole pipe freezes.
//       step_req while halted lets exactly one cycle run.
//     - Saturating counters of stall cycles and branch-flush events.
//
// Parameters:
//   CNT_W        : width of stall_count / flush_count
//   DRAIN_CYCLES : nop slots pushed into IF/ID before HALTED (>= 1)
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; all outputs read 0 while it is low
//   hz    : pipeline_hazard_ctrl_if.slave (status in, control out)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_STEP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic br;

    // Unmasked control outputs; reset gating is applied at the port.
    logic pc_we_raw;
    logic if_id_we_raw;
    logic if_id_flush_raw;
    logic id_ex_bubble_raw;
    logic ex_mem_flush_raw;
    logic pipe_en_raw;
    logic halted_raw;

    // Hazard detection: a load in EX whose destination (never $0) is a
    // source of the valid instruction in ID.
    always_comb begin
        lu = hz.id_valid & hz.ex_mem_read & (hz.ex_rt != 5'd0) &
             ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
        br = hz.mem_pc_src;
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        drain_cnt_d      = drain_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        flush_cnt_d      = flush_cnt_q;
        pc_we_raw        = 1'b0;
        if_id_we_raw     = 1'b0;
        if_id_flush_raw  = 1'b0;
        id_ex_bubble_raw = 1'b0;
        ex_mem_flush_raw = 1'b0;
        pipe_en_raw      = 1'b0;
        halted_raw       = 1'b0;

        unique case (state_q)
            // A STEP cycle behaves exactly like a RUN cycle; only the
            // successor state differs.
            ST_RUN, ST_STEP: begin
                pc_we_raw    = 1'b1;
                if_id_we_raw = 1'b1;
                pipe_en_raw  = 1'b1;
                if (br) begin
                    if_id_flush_raw  = 1'b1;
                    id_ex_bubble_raw = 1'b1;
                    ex_mem_flush_raw = 1'b1;
                    flush_cnt_d      = sat_inc(flush_cnt_q);
                end else if (lu) begin
                    pc_we_raw        = 1'b0;
                    if_id_we_raw     = 1'b0;
                    id_ex_bubble_raw = 1'b1;
                    stall_cnt_d      = sat_inc(stall_cnt_q);
                end

                if (state_q == ST_STEP) begin
                    state_d = hz.halt_req ? ST_HALTED : ST_RUN;
                end else if (hz.halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end

            // PC holds while IF/ID is loaded with nops, so whatever was
            // fetched this cycle is simply fetched again after the halt.
            ST_DRAIN: begin
                pc_we_raw       = 1'b0;
                if_id_we_raw    = 1'b1;
                if_id_flush_raw = 1'b1;
                pipe_en_raw     = 1'b1;
                if (br) begin
                    // Let the branch target into the PC and restart the drain
                    // so the wrong-path slots are not counted as drained.
                    pc_we_raw        = 1'b1;
                    id_ex_bubble_raw = 1'b1;
                    ex_mem_flush_raw = 1'b1;
                    flush_cnt_d      = sat_inc(flush_cnt_q);
                    drain_cnt_d      = DRAIN_LOAD;
                end else if (lu) begin
                    // The dependent instruction must stay in IF/ID, so the
                    // stall wins over the nop load and the drain pauses.
                    if_id_flush_raw  = 1'b0;
                    if_id_we_raw     = 1'b0;
                    id_ex_bubble_raw = 1'b1;
                    stall_cnt_d      = sat_inc(stall_cnt_q);
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end

                if (!hz.halt_req) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else if (!br && !lu && (drain_cnt_q <= DW'(1))) begin
                    state_d = ST_HALTED;
                end
            end

            ST_HALTED: begin
                halted_raw = 1'b1;
                if (hz.step_req) begin
                    state_d = ST_STEP;
                end else if (!hz.halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Every output reads 0 for as long as reset is held.
    assign hz.pc_we        = rst_n & pc_we_raw;
    assign hz.if_id_we     = rst_n & if_id_we_raw;
    assign hz.if_id_flush  = rst_n & if_id_flush_raw;
    assign hz.id_ex_bubble = rst_n & id_ex_bubble_raw;
    assign hz.ex_mem_flush = rst_n & ex_mem_flush_raw;
    assign hz.pipe_en      = rst_n & pipe_en_raw;
    assign hz.halted       = rst_n & halted_raw;
    assign hz.stall_count  = rst_n ? stall_cnt_q : '0;
    assign hz.flush_count  = rst_n ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two controllers share one stimulus stream: one with 16-bit counters and one
// with 2-bit counters so saturation is reached quickly. A behavioural model
// tracks "halted / stepping / drain slots left" plus the event counts and is
// compared with both controllers on every falling edge; directed literal
// checks pin both the model and the main controller at chosen points.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 4;
    localparam int MAX_M = 65535;
    localparam int MAX_S = 3;

    // Control-word layout: {pc_we, if_id_we, if_id_flush, id_ex_bubble,
    //                       ex_mem_flush, pipe_en, halted}
    localparam logic [6:0] C_RUN   = 7'b1100010;
    localparam logic [6:0] C_STALL = 7'b0001010;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_DRAIN = 7'b0110010;
    localparam logic [6:0] C_HALT  = 7'b0000001;
    localparam logic [6:0] C_ZERO  = 7'b0000000;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_pc_src;
    logic       halt_req;
    logic       step_req;

    logic nx_rst;
    logic nx_halt;

    int total;
    int bad;

    // Behavioural model state
    bit m_halted;
    bit m_stepping;
    int m_drain_left;
    int m_stall;
    int m_flush;
    int m_stall_s;
    int m_flush_s;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) ifm ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  ifs ();

    assign ifm.id_valid    = id_valid;
    assign ifm.id_rs       = id_rs;
    assign ifm.id_rt       = id_rt;
    assign ifm.id_uses_rt  = id_uses_rt;
    assign ifm.ex_mem_read = ex_mem_read;
    assign ifm.ex_rt       = ex_rt;
    assign ifm.mem_pc_src  = mem_pc_src;
    assign ifm.halt_req    = halt_req;
    assign ifm.step_req    = step_req;

    assign ifs.id_valid    = id_valid;
    assign ifs.id_rs       = id_rs;
    assign ifs.id_rt       = id_rt;
    assign ifs.id_uses_rt  = id_uses_rt;
    assign ifs.ex_mem_read = ex_mem_read;
    assign ifs.ex_rt       = ex_rt;
    assign ifs.mem_pc_src  = mem_pc_src;
    assign ifs.halt_req    = halt_req;
    assign ifs.step_req    = step_req;

    pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifm)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(DRAIN)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        return id_valid && ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic int sat(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    function automatic logic [6:0] ctrl_m();
        return {ifm.pc_we, ifm.if_id_we, ifm.if_id_flush, ifm.id_ex_bubble,
                ifm.ex_mem_flush, ifm.pipe_en, ifm.halted};
    endfunction

    function automatic logic [6:0] ctrl_s();
        return {ifs.pc_we, ifs.if_id_we, ifs.if_id_flush, ifs.id_ex_bubble,
                ifs.ex_mem_flush, ifs.pipe_en, ifs.halted};
    endfunction

    // What the control word must be this cycle, from the rules.
    function automatic logic [6:0] exp_ctrl();
        bit draining;
        if (!rst_n) return C_ZERO;
        if (m_halted && !m_stepping) return C_HALT;
        draining = (m_drain_left != 0);
        if (mem_pc_src) return C_BR;
        if (lu_now()) return C_STALL;
        return draining ? C_DRAIN : C_RUN;
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_halted     <= 1'b0;
            m_stepping   <= 1'b0;
            m_drain_left <= 0;
            m_stall      <= 0;
            m_flush      <= 0;
            m_stall_s    <= 0;
            m_flush_s    <= 0;
        end else if (m_halted && !m_stepping) begin
            if (step_req) m_stepping <= 1'b1;
            else if (!halt_req) m_halted <= 1'b0;
        end else begin
            if (mem_pc_src) begin
                m_flush   <= sat(m_flush, MAX_M);
                m_flush_s <= sat(m_flush_s, MAX_S);
            end else if (lu_now()) begin
                m_stall   <= sat(m_stall, MAX_M);
                m_stall_s <= sat(m_stall_s, MAX_S);
            end

            if (m_stepping) begin
                m_stepping <= 1'b0;
                m_halted   <= halt_req;
            end else if (m_drain_left > 0) begin
                if (!halt_req) begin
                    m_drain_left <= 0;
                end else if (mem_pc_src) begin
                    m_drain_left <= DRAIN;
                end else if (!lu_now()) begin
                    m_drain_left <= m_drain_left - 1;
                    if (m_drain_left == 1) m_halted <= 1'b1;
                end
            end else if (halt_req) begin
                m_drain_left <= DRAIN;
            end
        end
    end

    // Per-cycle comparison of both controllers against the model.
    always @(negedge clk) begin
        chk("ctrl_m",  32'(ctrl_m()), 32'(exp_ctrl()));
        chk("stall_m", 32'(ifm.stall_count), rst_n ? 32'(m_stall) : 32'd0);
        chk("flush_m", 32'(ifm.flush_count), rst_n ? 32'(m_flush) : 32'd0);
        chk("ctrl_s",  32'(ctrl_s()), 32'(exp_ctrl()));
        chk("stall_s", 32'(ifs.stall_count), rst_n ? 32'(m_stall_s) : 32'd0);
        chk("flush_s", 32'(ifs.flush_count), rst_n ? 32'(m_flush_s) : 32'd0);
    end

    // One clock: inputs change 1 ns after the rising edge, return at the
    // following falling edge where outputs are settled.
    task automatic cyc(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urt, input bit mr, input logic [4:0] ert,
                       input bit br, input bit stp);
        @(posedge clk);
        #1;
        rst_n       = nx_rst;
        halt_req    = nx_halt;
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = urt;
        ex_mem_read = mr;
        ex_rt       = ert;
        mem_pc_src  = br;
        step_req    = stp;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // lw $2 in EX, add using $2 as rs in ID
    task automatic ldu();
        cyc(1'b1, 5'd2, 5'd3, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    endtask

    task automatic brt();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic stp();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic lit(input string name, input logic [6:0] exp);
        chk(name, 32'(ctrl_m()), 32'(exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; halt_req = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; mem_pc_src = 1'b0;
        step_req = 1'b0;
        nx_rst = 1'b0;
        nx_halt = 1'b0;

        // Reset
        idle();
        idle();
        lit("rst_ctrl", C_ZERO);
        chk("rst_stall", 32'(ifm.stall_count), 32'd0);

        nx_rst = 1'b1;
        idle();
        lit("run_ctrl", C_RUN);
        chk("model_run", 32'(exp_ctrl()), 32'(C_RUN));

        // Load-use on rs
        ldu();
        lit("lu_ctrl", C_STALL);
        chk("lu_stall_before", 32'(ifm.stall_count), 32'd0);
        idle();
        chk("lu_stall_after", 32'(ifm.stall_count), 32'd1);
        chk("model_stall1", 32'(m_stall), 32'd1);

        // ex_rt = 0 never stalls
        cyc(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        lit("rt0_ctrl", C_RUN);
        idle();
        chk("rt0_stall", 32'(ifm.stall_count), 32'd1);

        // Match through rt only when rt is a source
        cyc(1'b1, 5'd4, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        lit("rt_use_ctrl", C_STALL);
        cyc(1'b1, 5'd4, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        lit("rt_nouse_ctrl", C_RUN);
        chk("rt_stall", 32'(ifm.stall_count), 32'd2);
        cyc(1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
        lit("invalid_ctrl", C_RUN);

        // Taken branch, then branch with coincident load-use
        brt();
        lit("br_ctrl", C_BR);
        cyc(1'b1, 5'd2, 5'd3, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
        lit("br_lu_ctrl", C_BR);
        chk("br_flush1", 32'(ifm.flush_count), 32'd1);
        idle();
        chk("br_flush2", 32'(ifm.flush_count), 32'd2);
        chk("br_lu_stall", 32'(ifm.stall_count), 32'd2);

        // Five back-to-back stalls: 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) ldu();
        idle();
        chk("sat_stall_s", 32'(ifs.stall_count), 32'd3);
        chk("sat_stall_m", 32'(ifm.stall_count), 32'd7);

        // Halt: one RUN cycle, four DRAIN cycles, then HALTED
        nx_halt = 1'b1;
        idle();
        lit("halt_run", C_RUN);
        for (int i = 0; i < DRAIN; i++) begin
            idle();
            lit("drain", C_DRAIN);
        end
        idle();
        lit("halted", C_HALT);

        // Single step
        stp();
        lit("step_req_cyc", C_HALT);
        idle();
        lit("step_cyc", C_RUN);
        idle();
        lit("step_back", C_HALT);

        // Step cycle with a load-use obeys the stall rule
        stp();
        ldu();
        lit("step_lu", C_STALL);
        idle();
        lit("step_lu_back", C_HALT);
        chk("step_lu_stall", 32'(ifm.stall_count), 32'd8);

        // Branch while halted is ignored
        brt();
        lit("halt_br", C_HALT);
        idle();
        chk("halt_br_flush", 32'(ifm.flush_count), 32'd2);

        // Release halt
        nx_halt = 1'b0;
        idle();
        lit("release_cyc", C_HALT);
        idle();
        lit("release_run", C_RUN);

        // Load-use during drain stretches it to five cycles
        nx_halt = 1'b1;
        idle();
        idle();
        lit("dl_d1", C_DRAIN);
        ldu();
        lit("dl_lu", C_STALL);
        idle();
        idle();
        idle();
        lit("dl_d5", C_DRAIN);
        idle();
        lit("dl_halted", C_HALT);
        nx_halt = 1'b0;
        idle();
        idle();
        lit("dl_run", C_RUN);

        // Branch during drain reloads the drain count
        nx_halt = 1'b1;
        idle();
        idle();
        brt();
        lit("db_br", C_BR);
        for (int i = 0; i < DRAIN; i++) begin
            idle();
            lit("db_drain", C_DRAIN);
        end
        idle();
        lit("db_halted", C_HALT);
        chk("db_flush_m", 32'(ifm.flush_count), 32'd3);
        chk("db_flush_s", 32'(ifs.flush_count), 32'd3);

        // Step with halt_req low: step wins, then RUN
        nx_halt = 1'b0;
        stp();
        lit("sr_req", C_HALT);
        idle();
        lit("sr_step", C_RUN);
        idle();
        lit("sr_run", C_RUN);

        // Flush counter saturation on the 2-bit instance
        brt();
        idle();
        chk("fsat_m", 32'(ifm.flush_count), 32'd4);
        chk("fsat_s", 32'(ifs.flush_count), 32'd3);

        // halt_req dropped mid-drain returns to RUN
        nx_halt = 1'b1;
        idle();
        idle();
        nx_halt = 1'b0;
        idle();
        lit("drop_drain", C_DRAIN);
        idle();
        lit("drop_run", C_RUN);

        // Reset in the middle of a drain
        nx_halt = 1'b1;
        idle();
        idle();
        nx_rst = 1'b0;
        idle();
        lit("rst_mid_ctrl", C_ZERO);
        chk("rst_mid_stall", 32'(ifm.stall_count), 32'd0);
        nx_rst  = 1'b1;
        nx_halt = 1'b0;
        idle();
        lit("rst_after_ctrl", C_RUN);
        chk("rst_after_stall", 32'(ifm.stall_count), 32'd0);
        chk("rst_after_flush", 32'(ifm.flush_count), 32'd0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeBack).
- Detects load-use hazards and inserts one-cycle stalls.
- Flushes wrong-path instructions when a branch resolves taken in the memory stage.
- Provides a debug halt/drain/single-step FSM, plus saturating stall and flush event counters for bench observation.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- DRAIN_CYCLES, 4, bubbles injected into IF/ID before entering HALTED.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  MemRead bit of ID/EX M field (load in EX).
- ex_rt  in  5  destination register of the instruction in EX.
- mem_pc_src  in  1  PCSrc from the memory stage (branch taken).
- halt_req  in  1  level; request halt.
- step_req  in  1  one-cycle pulse; single-step while halted.
- pc_we  out  1  PC register load enable.
- if_id_we  out  1  IF/ID load enable.
- if_id_flush  out  1  load zero (nop) into IF/ID.
- id_ex_bubble  out  1  load zero control fields (WB/M/EX) into ID/EX.
- ex_mem_flush  out  1  zero WB/M fields entering EX/MEM.
- pipe_en  out  1  load enable for ID/EX, EX/MEM, MEM/WB.
- halted  out  1  FSM in HALTED.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=RUN, drain_cnt=0, both counts=0.
  - While rst_n=0, all outputs are forced to 0.
- Hazard detection is combinational, same cycle:
  - lu = id_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
  - br = mem_pc_src.
- Default (RUN, no event): pc_we=1, if_id_we=1, pipe_en=1, all flush/bubble outputs 0.
- br (any non-HALTED state; highest priority):
  - pc_we=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
  - lu is ignored that cycle.
  - flush_count += 1.
- lu without br:
  - pc_we=0, if_id_we=0, id_ex_bubble=1.
  - stall_count += 1.
  - Exactly one bubble per load; the next cycle the load is in MEM, so lu falls naturally.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FSM states: RUN, DRAIN, HALTED, STEP.
  - RUN -> DRAIN when halt_req=1; drain_cnt loads DRAIN_CYCLES.
  - DRAIN:
    - pc_we=0 (PC holds, so the fetched instruction is refetched later), if_id_flush=1, pipe_en=1.
    - drain_cnt decrements each cycle; go to HALTED when drain_cnt reaches 1 and decrements.
    - If lu: stall overrides flush (if_id_flush=0, if_id_we=0, id_ex_bubble=1) and drain_cnt holds.
    - If br: branch flush applies with pc_we=1 (target captured), and drain_cnt reloads DRAIN_CYCLES.
    - If halt_req drops: go to RUN next cycle, with no instruction lost.
  - HALTED:
    - pc_we=0, if_id_we=0, pipe_en=0, halted=1.
    - br and lu are ignored; counters hold.
    - halt_req=0 -> RUN.
    - step_req=1 -> STEP (step_req takes priority if both).
  - STEP:
    - Exactly one cycle with RUN output rules, including hazards and counters.
    - Returns to HALTED if halt_req=1, else RUN.
- step_req outside HALTED is ignored.
- State registers update only on rising clk.
- Reset mid-DRAIN or mid-STEP returns to RUN with counters cleared.

Test Plan:
- Load-use: lw $2 in EX (ex_mem_read=1, ex_rt=2), ID add with id_rs=2 -> one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1; stall_count 0->1; with ex_rt=0 instead -> no stall.
- Taken branch: mem_pc_src=1 for one cycle -> pc_we=1, if_id_flush=ex_mem_flush=id_ex_bubble=1; flush_count=1; simultaneous lu gives no stall and stall_count unchanged.
- Halt/drain: halt_req=1 in RUN -> 4 cycles DRAIN with if_id_flush=1 and pc_we=0, then halted=1, pipe_en=0; a lu during drain extends DRAIN to 5 cycles.
- Single step: in HALTED pulse step_req -> exactly one cycle pc_we=pipe_en=1, then halted=1 again; drop halt_req -> RUN next cycle.
- Saturation: CNT_W=2, five consecutive lu stall cycles -> stall_count stops at 3.
- Reset: rst_n=0 during DRAIN -> next edge all outputs 0; after release, state=RUN and counts=0.
